// File: rtl/ps2_pkg.sv
// ps2_pkg: receiver state encoding, parameter defaults and parity helper shared by keyboard blocks
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
   localparam int FILTER_LEN_DEF  = 8;
   localparam int TIMEOUT_CYC_DEF = 50000;
   function automatic logic odd_ones(input logic [8:0] v);
      return ^v;
   endfunction
endpackage

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: PS/2 pins plus received-byte bus
//   ps2_clk, ps2_data : raw PS/2 pins, asynchronous to the system clock
//   scan_code         : last good byte; code_valid/parity_err/frame_err are one-cycle pulses
//   clk_filt          : glitch-filtered PS/2 clock level, for observation
//   master = receiver side, slave = pin driver / byte consumer side
interface ps2_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       clk_filt;
   logic [7:0] scan_code;
   logic       code_valid;
   logic       parity_err;
   logic       frame_err;
   modport master (input ps2_clk, ps2_data, output clk_filt, scan_code, code_valid, parity_err, frame_err);
   modport slave  (output ps2_clk, ps2_data, input clk_filt, scan_code, code_valid, parity_err, frame_err);
endinterface

// File: rtl/ps2_filter.sv
// ps2_filter: two-flop synchronizers for both pins and a run-length glitch filter on ps2_clk
//   clk, reset_n      : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data : raw pins
//   clk_filt          : filtered clock level
//   fall              : one-cycle strobe on the cycle clk_filt becomes 0
//   data_s            : synchronized data, to be sampled while fall is high
module ps2_filter #(
   parameter int FILTER_LEN = ps2_pkg::FILTER_LEN_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic clk_filt,
   output logic fall,
   output logic data_s
);
   localparam int CW = $clog2(FILTER_LEN + 1);
   logic [1:0]    cs, ds;
   logic [CW-1:0] cnt;
   logic          flip;
   assign data_s = ds[1];
   // cnt holds how many consecutive samples already disagreed with clk_filt
   assign flip = (cs[1] != clk_filt) && (cnt == CW'(FILTER_LEN - 1));
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cs       <= 2'b11;
         ds       <= 2'b11;
         cnt      <= '0;
         clk_filt <= 1'b1;
         fall     <= 1'b0;
      end else begin
         cs       <= {cs[0], ps2_clk};
         ds       <= {ds[0], ps2_data};
         cnt      <= (cs[1] == clk_filt || flip) ? '0 : cnt + 1'b1;
         clk_filt <= flip ? cs[1] : clk_filt;
         fall     <= flip & clk_filt;
      end
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard frame receiver (start, 8 data LSB first, odd parity, stop)
//   clk, reset_n : 50 MHz system clock, asynchronous active-low reset
//   bus          : ps2_rx_if master -- raw pins in; scan_code, code_valid, parity_err, frame_err out
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = FILTER_LEN_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input logic      clk,
   input logic      reset_n,
   ps2_rx_if.master bus
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   ps2_state_t    state, state_n;
   logic [2:0]    bits, bits_n;
   logic [7:0]    sr, sr_n, code_n;
   logic          par, par_n, cv_n, pe_n, fe_n;
   logic [TW-1:0] tmo, tmo_n;
   logic          fall, d, tmo_hit;
   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk      (clk),
      .reset_n  (reset_n),
      .ps2_clk  (bus.ps2_clk),
      .ps2_data (bus.ps2_data),
      .clk_filt (bus.clk_filt),
      .fall     (fall),
      .data_s   (d)
   );
   assign tmo_hit = tmo == TW'(TIMEOUT_CYC);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state          <= IDLE;
         bits           <= '0;
         sr             <= '0;
         par            <= 1'b0;
         tmo            <= '0;
         bus.scan_code  <= '0;
         bus.code_valid <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
      end else begin
         state          <= state_n;
         bits           <= bits_n;
         sr             <= sr_n;
         par            <= par_n;
         tmo            <= tmo_n;
         bus.scan_code  <= code_n;
         bus.code_valid <= cv_n;
         bus.parity_err <= pe_n;
         bus.frame_err  <= fe_n;
      end
   // an edge is handled before the timeout check, so it wins a same-cycle tie
   always_comb begin
      state_n = state;
      bits_n  = bits;
      sr_n    = sr;
      par_n   = par;
      code_n  = bus.scan_code;
      cv_n    = 1'b0;
      pe_n    = 1'b0;
      fe_n    = 1'b0;
      tmo_n   = (state == IDLE || fall) ? '0 : tmo_hit ? tmo : tmo + 1'b1;
      if (fall)
         case (state)
            IDLE: begin
               state_n = d ? IDLE : DATA;
               bits_n  = '0;
            end
            DATA: begin
               sr_n    = {d, sr[7:1]};
               bits_n  = bits + 1'b1;
               state_n = (bits == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               par_n   = d;
               state_n = STOP;
            end
            default: begin
               state_n = IDLE;
               fe_n    = ~d;
               cv_n    = d & odd_ones({sr, par});
               pe_n    = d & ~odd_ones({sr, par});
               code_n  = cv_n ? sr : bus.scan_code;
            end
         endcase
      else if (state != IDLE && tmo_hit) begin
         state_n = IDLE;
         fe_n    = 1'b1;
      end
   end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: table-driven and randomized frame checks against a frame-level model
module tb_ps2_rx;
   import ps2_pkg::*;
   localparam int H   = 30;
   localparam int TMO = 400;
   typedef struct {
      logic [7:0] d;
      bit         par_ok;
      bit         stop;
      int         kind;
      logic [7:0] code;
   } vec_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0, n_fail = 0;
   int   n_cv = 0, n_pe = 0, n_fe = 0, n_multi = 0;
   logic [7:0] code_at_cv = 8'h00;
   ps2_rx_if bus ();
   ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );
   always #10 clk = ~clk;
   always @(negedge clk) begin
      if (bus.code_valid) begin
         n_cv       <= n_cv + 1;
         code_at_cv <= bus.scan_code;
      end
      if (bus.parity_err) n_pe <= n_pe + 1;
      if (bus.frame_err) n_fe <= n_fe + 1;
      if (int'(bus.code_valid) + int'(bus.parity_err) + int'(bus.frame_err) > 1) n_multi <= n_multi + 1;
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [10:0] mk(input logic [7:0] d, input bit par_ok, input bit stop);
      logic p;
      p = par_ok ? ~^d : ^d;
      return {stop, p, d, 1'b0};
   endfunction
   // 0 = good byte, 1 = parity error, 2 = framing error
   function automatic int model_kind(input logic [10:0] f);
      if (!f[10]) return 2;
      return ($countones(f[9:1]) % 2 == 1) ? 0 : 1;
   endfunction
   task automatic send_bits(input logic [10:0] f, input int lo, input int hi, input bit glitch);
      for (int i = lo; i <= hi; i++) begin
         @(negedge clk);
         bus.ps2_data = f[i];
         if (glitch) begin
            repeat (H / 2) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (H / 2 - 3) @(negedge clk);
         end else
            repeat (H) @(negedge clk);
         bus.ps2_clk = 1'b0;
         repeat (H) @(negedge clk);
         bus.ps2_clk = 1'b1;
      end
   endtask
   task automatic frame(input string name, input logic [10:0] f, input int kind, input logic [7:0] code, input bit glitch);
      int cv0, pe0, fe0, m0;
      cv0 = n_cv;
      pe0 = n_pe;
      fe0 = n_fe;
      m0  = n_multi;
      send_bits(f, 0, 10, glitch);
      repeat (40) @(negedge clk);
      check({name, " code_valid"}, 32'(n_cv - cv0), 32'(kind == 0));
      check({name, " parity_err"}, 32'(n_pe - pe0), 32'(kind == 1));
      check({name, " frame_err"}, 32'(n_fe - fe0), 32'(kind == 2));
      check({name, " scan_code"}, 32'(bus.scan_code), 32'(code));
      check({name, " pulse overlap"}, 32'(n_multi - m0), 32'd0);
      check({name, " state"}, 32'(dut.state), 32'(IDLE));
      if (kind == 0) check({name, " code at valid"}, 32'(code_at_cv), 32'(code));
   endtask
   initial begin
      vec_t       tbl [8];
      logic [10:0] f;
      logic [7:0]  exp_code;
      int          k, cv0, fe0;
      tbl[0] = '{8'h1C, 1'b1, 1'b1, 0, 8'h1C};
      tbl[1] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C};
      tbl[2] = '{8'hF0, 1'b1, 1'b0, 2, 8'h1C};
      tbl[3] = '{8'h1C, 1'b1, 1'b1, 0, 8'h1C};
      tbl[4] = '{8'h00, 1'b1, 1'b1, 0, 8'h00};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 0, 8'hFF};
      tbl[6] = '{8'h5A, 1'b0, 1'b1, 1, 8'hFF};
      tbl[7] = '{8'h81, 1'b0, 1'b0, 2, 8'hFF};
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      check("reset scan_code", 32'(bus.scan_code), 32'h0);
      check("reset pulses", 32'({bus.code_valid, bus.parity_err, bus.frame_err}), 32'h0);
      check("reset state", 32'(dut.state), 32'(IDLE));
      check("reset clk_filt", 32'(bus.clk_filt), 32'h1);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      fe0 = n_fe;
      bus.ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
      check("idle glitch clk_filt", 32'(bus.clk_filt), 32'h1);
      send_bits(11'h7FF, 0, 0, 1'b0);
      repeat (20) @(negedge clk);
      check("idle data=1 edge state", 32'(dut.state), 32'(IDLE));
      check("idle data=1 edge no error", 32'(n_fe - fe0), 32'h0);
      for (int i = 0; i < 8; i++)
         frame($sformatf("table[%0d]", i), mk(tbl[i].d, tbl[i].par_ok, tbl[i].stop), tbl[i].kind, tbl[i].code, 1'b0);
      exp_code = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         f = mk(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         k = model_kind(f);
         if (k == 0) exp_code = f[8:1];
         frame($sformatf("rand[%0d]", i), f, k, exp_code, 1'b0);
      end
      frame("glitch frame", mk(8'h3C, 1'b1, 1'b1), 0, 8'h3C, 1'b1);
      cv0 = n_cv;
      fe0 = n_fe;
      send_bits(mk(8'hA5, 1'b1, 1'b1), 0, 4, 1'b0);
      repeat (5) @(negedge clk);
      check("timeout mid-frame state", 32'(dut.state), 32'(DATA));
      repeat (TMO + 50) @(negedge clk);
      check("timeout frame_err", 32'(n_fe - fe0), 32'h1);
      check("timeout code_valid", 32'(n_cv - cv0), 32'h0);
      check("timeout state", 32'(dut.state), 32'(IDLE));
      check("timeout scan_code", 32'(bus.scan_code), 32'h3C);
      frame("after timeout", mk(8'h5A, 1'b1, 1'b1), 0, 8'h5A, 1'b0);
      f = mk(8'h1C, 1'b1, 1'b1);
      send_bits(f, 0, 4, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      check("async reset scan_code", 32'(bus.scan_code), 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      cv0 = n_cv;
      send_bits(f, 5, 10, 1'b0);
      repeat (40) @(negedge clk);
      check("reset resume code_valid", 32'(n_cv - cv0), 32'h0);
      check("reset resume scan_code", 32'(bus.scan_code), 32'h0);
      repeat (TMO + 50) @(negedge clk);
      check("reset resume settles idle", 32'(dut.state), 32'(IDLE));
      check("reset resume still no code", 32'(n_cv - cv0), 32'h0);
      frame("after reset", mk(8'h1C, 1'b1, 1'b1), 0, 8'h1C, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples needed to accept a level change.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: idle clk cycles allowed between bit edges inside a frame (1 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1, single system clock, 50 MHz on the DE2-115.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1, raw PS/2 clock pin, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1, raw PS/2 data pin, asynchronous to clk.
REQ-007 SHALL have port scan_code, output, 8, last good received byte, held stable until the next good frame; it drives two downstream hexdigit nibble decoders.
REQ-008 SHALL have port code_valid, output, 1, one-cycle pulse when scan_code updates.
REQ-009 SHALL have port parity_err, output, 1, one-cycle pulse on an odd-parity failure.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit or a timeout.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through two-flop synchronizers before any use.
REQ-012 SHALL change the filtered ps2_clk level only after FILTER_LEN consecutive equal synchronized samples.
REQ-013 SHALL act only on the filtered ps2_clk 1->0 transition ("edge") and SHALL sample synchronized ps2_data on the edge cycle.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
- IDLE: on an edge with data=0 (start bit), go to DATA and clear the bit count; with data=1, stay in IDLE and flag no error.
REQ-015 DATA SHALL shift 8 bits LSB first; after the 8th edge it goes to PARITY.
REQ-016 PARITY SHALL capture the parity bit, then go to STOP.
REQ-017 STOP SHALL close the frame on its edge and always return to IDLE.
- If stop=1 and the 8 data bits plus the parity bit contain an odd number of ones: load scan_code and pulse code_valid.
- If stop=1 and parity is even: pulse parity_err only; scan_code is unchanged.
- If stop=0: pulse frame_err only, whatever the parity.
REQ-018 SHALL assert each pulse exactly one cycle after the stop-bit edge cycle; scan_code SHALL update on the same cycle code_valid is asserted.
REQ-019 SHALL run a timeout counter in any state other than IDLE; it resets on every edge.
REQ-020 SHALL, when the timeout counter reaches TIMEOUT_CYC, return to IDLE, discard the partial byte, and pulse frame_err.
REQ-021 SHALL give the edge priority when an edge and the timeout occur in the same cycle.
REQ-022 SHALL never assert more than one of code_valid, parity_err and frame_err in the same cycle.
REQ-023 SHALL size the timeout counter to $clog2(TIMEOUT_CYC+1) bits and SHALL saturate it, never wrap.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force:
- state = IDLE, scan_code = 8'h00;
- code_valid, parity_err, frame_err = 0;
- synchronizers and filtered clock = 1; counters = 0.
REQ-025 SHALL, after reset is released in the middle of a frame, ignore edges until a valid start bit is seen from IDLE.

Structure
REQ-026 SHALL place the state encoding (IDLE, DATA, PARITY, STOP) and the defaults for FILTER_LEN and TIMEOUT_CYC in a shared ps2_pkg, which later keyboard blocks reuse.
REQ-027 SHALL implement the synchronizer and glitch filter as one sub-module, ps2_filter, that outputs a filtered clock and a one-cycle falling-edge strobe.

Verification
REQ-028 Good frame, key A: send 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) with a 40 us PS/2 period -> scan_code=8'h1C, code_valid high exactly 1 cycle, no error pulse.
REQ-029 Bad parity: send 0x1C with parity 1 -> parity_err pulses 1 cycle, scan_code keeps its previous value 8'h1C, code_valid stays 0.
REQ-030 Bad stop: send 0xF0 with stop 0 -> frame_err pulses 1 cycle, scan_code unchanged, state returns to IDLE; a following good 0x1C is received correctly.
REQ-031 Timeout: stop ps2_clk after 4 data bits for more than 50000 cycles -> frame_err pulses once, state is IDLE; a following good 0x5A yields scan_code=8'h5A.
REQ-032 Glitch: inject 3-cycle low pulses on ps2_clk in IDLE and mid-frame -> no state change and no bit shifted; the frame still decodes correctly.
REQ-033 Reset mid-frame: assert reset_n=0 after the 5th bit, release, resume clocking the old frame's remaining bits -> no code_valid; scan_code=8'h00 until a complete new frame arrives.
